// File: rtl/accel_cmd_sequencer.sv
// Command sequencer for the matrix-multiply accelerator: polls a ring of
// control-BRAM slots in order, issues descriptors to the core, writes status back.
module accel_cmd_sequencer #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_BASE   = 0,
  parameter int CTRL_ADDR_W = 9,
  parameter int LANE_LOG2   = 3,
  parameter int COUNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [CTRL_ADDR_W-1:0] ctrl_addr,
  output logic [63:0]            ctrl_din,
  input  logic [63:0]            ctrl_dout,
  output logic                   ctrl_en,
  output logic                   ctrl_we,
  output logic                   core_valid,
  input  logic                   core_ready,
  input  logic                   core_gnt,
  output logic [16-LANE_LOG2:0]  a_size,
  output logic [16-LANE_LOG2:0]  b_size,
  output logic [15:0]            n_size,
  output logic                   busy,
  output logic [COUNT_W-1:0]     done_count
);

  localparam int SIZE_W = 17 - LANE_LOG2;
  localparam int PTR_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [15:0] LANE_MASK = 16'((32'd1 << LANE_LOG2) - 32'd1);

  localparam logic [2:0] ST_POLL_A  = 3'd0;
  localparam logic [2:0] ST_POLL_C  = 3'd1;
  localparam logic [2:0] ST_FETCH_A = 3'd2;
  localparam logic [2:0] ST_FETCH_C = 3'd3;
  localparam logic [2:0] ST_ISSUE   = 3'd4;
  localparam logic [2:0] ST_EXEC    = 3'd5;
  localparam logic [2:0] ST_WB      = 3'd6;

  function automatic logic [SIZE_W-1:0] round_size(input logic [15:0] raw);
    logic [15:0] whole_s;
    whole_s    = raw >> LANE_LOG2;
    round_size = SIZE_W'(whole_s) + SIZE_W'((raw & LANE_MASK) != 16'd0);
  endfunction

  // Flag word at base+4*slot, descriptor word two words above it.
  function automatic logic [CTRL_ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] p,
                                                       input logic             desc);
    slot_addr = CTRL_ADDR_W'(SLOT_BASE) + CTRL_ADDR_W'({p, desc, 1'b0});
  endfunction

  logic [2:0]             state_r;
  logic [2:0]             next_state_s;
  logic [PTR_W-1:0]       ptr_r;
  logic [PTR_W-1:0]       next_ptr_s;
  logic [SIZE_W-1:0]      a_round_s;
  logic [SIZE_W-1:0]      b_round_s;
  logic                   size_zero_s;
  logic [COUNT_W-1:0]     seq_s;
  logic [63:0]            status_s;
  logic [CTRL_ADDR_W-1:0] addr_s;
  logic                   unused_s;

  assign ctrl_en  = 1'b1;
  assign unused_s = ^ctrl_dout[63:48];

  // Descriptor rounding and status word assembly.
  always_comb begin
    a_round_s   = round_size(ctrl_dout[15:0]);
    b_round_s   = round_size(ctrl_dout[31:16]);
    size_zero_s = (a_round_s == {SIZE_W{1'b0}}) || (b_round_s == {SIZE_W{1'b0}}) ||
                  (ctrl_dout[47:32] == 16'd0);
    seq_s       = done_count + COUNT_W'(1);
    // Only FETCH_C can enter WB on the error path.
    status_s    = {32'd0, 16'(seq_s), 13'd0, (state_r == ST_FETCH_C), 1'b1, 1'b0};
  end

  // Next-state, next-pointer and next-address logic.
  always_comb begin
    next_state_s = state_r;
    next_ptr_s   = ptr_r;
    addr_s       = slot_addr(ptr_r, 1'b0);
    case (state_r)
      ST_POLL_A:  next_state_s = ST_POLL_C;
      ST_POLL_C: begin
        if (ctrl_dout[0] && enable) begin
          next_state_s = ST_FETCH_A;
        end else begin
          next_state_s = ST_POLL_A;
        end
      end
      ST_FETCH_A: next_state_s = ST_FETCH_C;
      ST_FETCH_C: begin
        if (size_zero_s) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_ready) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_EXEC: begin
        if (core_gnt) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_WB: begin
        next_state_s = ST_POLL_A;
        if (ptr_r == PTR_W'(NUM_SLOTS - 1)) begin
          next_ptr_s = {PTR_W{1'b0}};
        end else begin
          next_ptr_s = ptr_r + PTR_W'(1);
        end
      end
      default: next_state_s = ST_POLL_A;
    endcase
    case (next_state_s)
      ST_FETCH_A, ST_FETCH_C, ST_ISSUE, ST_EXEC: addr_s = slot_addr(next_ptr_s, 1'b1);
      default:                                   addr_s = slot_addr(next_ptr_s, 1'b0);
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_POLL_A;
      ptr_r      <= {PTR_W{1'b0}};
      done_count <= {COUNT_W{1'b0}};
      ctrl_addr  <= slot_addr({PTR_W{1'b0}}, 1'b0);
      ctrl_din   <= 64'd0;
      ctrl_we    <= 1'b0;
      core_valid <= 1'b0;
      busy       <= 1'b0;
      a_size     <= {SIZE_W{1'b0}};
      b_size     <= {SIZE_W{1'b0}};
      n_size     <= 16'd0;
    end else begin
      state_r    <= next_state_s;
      ptr_r      <= next_ptr_s;
      ctrl_addr  <= addr_s;
      ctrl_we    <= (next_state_s == ST_WB);
      core_valid <= (next_state_s == ST_ISSUE);
      busy       <= (next_state_s != ST_POLL_A) && (next_state_s != ST_POLL_C);
      if (next_state_s == ST_WB) begin
        ctrl_din <= status_s;
      end
      if (state_r == ST_FETCH_C) begin
        a_size <= a_round_s;
        b_size <= b_round_s;
        n_size <= ctrl_dout[47:32];
      end
      if (state_r == ST_WB) begin
        done_count <= done_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Self-checking bench for accel_cmd_sequencer: BRAM model, scripted core,
// expected timing derived from the poll phase and the documented latencies.
module tb_accel_cmd_sequencer;

  localparam int NS = 4;
  localparam int SB = 8;
  localparam int AW = 9;
  localparam int LL = 3;
  localparam int CW = 16;
  localparam int SW = 17 - LL;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [AW-1:0] ctrl_addr;
  logic [63:0]   ctrl_din;
  logic [63:0]   ctrl_dout;
  logic          ctrl_en;
  logic          ctrl_we;
  logic          core_valid;
  logic          core_ready;
  logic          core_gnt;
  logic [SW-1:0] a_size;
  logic [SW-1:0] b_size;
  logic [15:0]   n_size;
  logic          busy;
  logic [CW-1:0] done_count;

  accel_cmd_sequencer #(
    .NUM_SLOTS(NS), .SLOT_BASE(SB), .CTRL_ADDR_W(AW), .LANE_LOG2(LL), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ctrl_addr(ctrl_addr), .ctrl_din(ctrl_din), .ctrl_dout(ctrl_dout),
    .ctrl_en(ctrl_en), .ctrl_we(ctrl_we),
    .core_valid(core_valid), .core_ready(core_ready), .core_gnt(core_gnt),
    .a_size(a_size), .b_size(b_size), .n_size(n_size),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Control BRAM: one-cycle read latency, write-first on the DUT port,
  // bench writes land one edge later than a same-edge read.
  logic [63:0]   mem [0:(1<<AW)-1];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [63:0]   tb_data;
  always @(posedge clk) begin
    if (ctrl_we) ctrl_dout <= ctrl_din;
    else         ctrl_dout <= mem[ctrl_addr];
    if (ctrl_we) mem[ctrl_addr] <= ctrl_din;
    if (tb_we)   mem[tb_addr] <= tb_data;
  end

  int total = 0;
  int bad   = 0;
  int anchor;      // a cycle known to be a poll-address cycle
  int exp_count;
  int da [NS];
  int db [NS];
  int dn [NS];
  int v;
  int v1;

  function automatic int flag_a(int s);
    return SB + 4 * s;
  endfunction

  function automatic int desc_a(int s);
    return SB + 4 * s + 2;
  endfunction

  function automatic int ceil_lane(int raw);
    return (raw + (1 << LL) - 1) / (1 << LL);
  endfunction

  function automatic logic [63:0] status_of(int seq, bit err);
    longint w;
    w = longint'(seq % 65536) * 65536 + 2 + (err ? 4 : 0);
    return 64'(w);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic mem_write(int a, logic [63:0] d, output int vis);
    tb_we   = 1'b1;
    tb_addr = AW'(a);
    tb_data = d;
    vis     = cyc + 2;
    step();
    tb_we   = 1'b0;
  endtask

  task automatic load_desc(int s, int a, int b, int n);
    int unused_vis;
    da[s] = a; db[s] = b; dn[s] = n;
    mem_write(desc_a(s), {16'd0, 16'(n), 16'(b), 16'(a)}, unused_vis);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_valid"}, 64'(core_valid), 64'd0);
    check({tag, "_we"},    64'(ctrl_we),    64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_asz"},   64'(a_size),     64'd0);
    check({tag, "_bsz"},   64'(b_size),     64'd0);
    check({tag, "_nsz"},   64'(n_size),     64'd0);
    check({tag, "_din"},   ctrl_din,        64'd0);
    check({tag, "_cnt"},   64'(done_count), 64'd0);
    check({tag, "_addr"},  64'(ctrl_addr),  64'(flag_a(0)));
  endtask

  // Runs one command on slot s; go becomes readable from cycle go_cyc.
  task automatic do_cmd(int s, int rdly, int gdly, bit early, bit rst_exec, int go_cyc);
    int  ea, eb, pc;
    bit  err;
    ea  = ceil_lane(da[s]);
    eb  = ceil_lane(db[s]);
    err = (ea == 0) || (eb == 0) || (dn[s] == 0);
    pc  = (go_cyc > anchor) ? go_cyc : anchor;
    if (((pc - anchor) % 2) == 0) pc++;
    wait_until(pc + 1);
    check("fetch_busy",  64'(busy),       64'd1);
    check("fetch_valid", 64'(core_valid), 64'd0);
    wait_until(pc + 2);
    check("fetchc_valid", 64'(core_valid), 64'd0);
    check("fetchc_addr",  64'(ctrl_addr),  64'(desc_a(s)));
    wait_until(pc + 3);
    check("a_size", 64'(a_size), 64'(ea));
    check("b_size", 64'(b_size), 64'(eb));
    check("n_size", 64'(n_size), 64'(dn[s]));
    if (err) begin
      check("err_no_valid", 64'(core_valid), 64'd0);
      check("err_wb_we",    64'(ctrl_we),    64'd1);
      check("err_wb_addr",  64'(ctrl_addr),  64'(flag_a(s)));
      check("err_wb_din",   ctrl_din,        status_of(exp_count + 1, 1'b1));
      step();
    end else begin
      check("valid_rise", 64'(core_valid), 64'd1);
      check("issue_we",   64'(ctrl_we),    64'd0);
      for (int i = 0; i < rdly; i++) begin
        core_ready = 1'b0;
        core_gnt   = early && (i == rdly / 2);
        step();
        check("bp_valid", 64'(core_valid), 64'd1);
        check("bp_asize", 64'(a_size),     64'(ea));
        check("bp_no_wb", 64'(ctrl_we),    64'd0);
      end
      core_gnt   = 1'b0;
      core_ready = 1'b1;
      step();
      core_ready = 1'b0;
      check("valid_drop", 64'(core_valid), 64'd0);
      check("exec_busy",  64'(busy),       64'd1);
      if (rst_exec) begin
        step();
        step();
        rst = 1'b1;
        step();
        check_reset("rst_exec");
        check("flag_untouched", 64'(mem[AW'(flag_a(s))]), 64'd1);
        step();
        rst       = 1'b0;
        anchor    = cyc;
        exp_count = 0;
        return;
      end
      for (int i = 1; i < gdly; i++) begin
        step();
        check("exec_wait_we", 64'(ctrl_we), 64'd0);
      end
      core_gnt = 1'b1;
      step();
      core_gnt = 1'b0;
      check("wb_we",   64'(ctrl_we),   64'd1);
      check("wb_addr", 64'(ctrl_addr), 64'(flag_a(s)));
      check("wb_din",  ctrl_din,       status_of(exp_count + 1, 1'b0));
      step();
    end
    exp_count++;
    check("done_count", 64'(done_count), 64'(exp_count % 65536));
    check("flag_word",  mem[AW'(flag_a(s))], status_of(exp_count, err));
    check("post_we",    64'(ctrl_we),   64'd0);
    check("post_busy",  64'(busy),      64'd0);
    check("post_addr",  64'(ctrl_addr), 64'(flag_a((s + 1) % NS)));
    anchor = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; core_ready = 1'b0; core_gnt = 1'b0;
    tb_we = 1'b0; tb_addr = '0; tb_data = 64'd0;
    exp_count = 0; anchor = 0;
    step();
    for (int s = 0; s < NS; s++) mem_write(flag_a(s), 64'd0, v);
    check_reset("reset");
    check("ctrl_en", 64'(ctrl_en), 64'd1);
    rst    = 1'b0;
    anchor = cyc;

    // Single command on slot 0.
    load_desc(0, 17, 16, 5);
    mem_write(flag_a(0), 64'd1, v);
    do_cmd(0, 0, 10, 1'b0, 1'b0, v);

    // All four slots armed; ptr is at 1 so order is 1,2,3 then wrap to 0.
    load_desc(1, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)),
              int'($urandom_range(1, 65535)));
    load_desc(2, 65535, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)));
    load_desc(3, int'($urandom_range(1, 7)), 8, 0);
    load_desc(0, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)),
              int'($urandom_range(1, 65535)));
    mem_write(flag_a(0), 64'd1, v);
    mem_write(flag_a(3), 64'd1, v);
    mem_write(flag_a(2), 64'd1, v);
    mem_write(flag_a(1), 64'd1, v1);
    do_cmd(1, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, 1'b0, v1);
    do_cmd(2, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 0);
    do_cmd(3, 0, 1, 1'b0, 1'b0, 0);
    do_cmd(0, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 0);

    // Zero B size.
    load_desc(1, int'($urandom_range(1, 65535)), 0, int'($urandom_range(1, 65535)));
    mem_write(flag_a(1), 64'd1, v);
    do_cmd(1, 0, 1, 1'b0, 1'b0, v);

    // Backpressure with an early grant during ISSUE.
    load_desc(2, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)),
              int'($urandom_range(1, 65535)));
    mem_write(flag_a(2), 64'd1, v);
    do_cmd(2, 20, 5, 1'b1, 1'b0, v);

    // enable low while go is set.
    enable = 1'b0;
    load_desc(3, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)),
              int'($urandom_range(1, 65535)));
    mem_write(flag_a(3), 64'd1, v);
    for (int i = 0; i < 12; i++) begin
      step();
      check("en_low_valid", 64'(core_valid), 64'd0);
      check("en_low_busy",  64'(busy),       64'd0);
    end
    enable = 1'b1;
    do_cmd(3, 1, 3, 1'b0, 1'b0, cyc);

    // Reset in EXEC, then the same slot re-executes from a fresh count.
    load_desc(0, int'($urandom_range(1, 65535)), int'($urandom_range(1, 65535)),
              int'($urandom_range(1, 65535)));
    mem_write(flag_a(0), 64'd1, v);
    do_cmd(0, 0, 5, 1'b0, 1'b1, v);
    do_cmd(0, int'($urandom_range(0, 2)), 4, 1'b0, 1'b0, anchor);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_cmd_sequencer.md
# accel_cmd_sequencer

Parametrised command sequencer for the matrix-multiply accelerator. It polls a ring of NUM_SLOTS command slots in the control BRAM and rounds each descriptor's A/B sizes up to lane granularity. It issues each descriptor to the matrix core over a valid/ready handshake, waits for the core's completion grant, then writes a status word back into the slot's flag word. It replaces the single-slot fetch FSM in front of the matrix core, adding multi-slot ordering, zero-size error reporting, a pause input and a completion counter.

## Interface
- NUM_SLOTS, 4, number of command slots; power of two, 1..64
- SLOT_BASE, 0, control-BRAM word address of slot 0
- CTRL_ADDR_W, 9, control-BRAM address width
- LANE_LOG2, 3, log2 of lane width used for A/B size rounding; 1..8
- COUNT_W, 16, width of the completion counter
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  when low, no new command is accepted; an in-flight command still completes
- ctrl_addr  out  CTRL_ADDR_W  control-BRAM address
- ctrl_din  out  64  control-BRAM write data
- ctrl_dout  in  64  control-BRAM read data; valid one cycle after the address is driven
- ctrl_en  out  1  control-BRAM enable; constant 1
- ctrl_we  out  1  control-BRAM write enable
- core_valid  out  1  descriptor valid to the matrix core
- core_ready  in  1  matrix core accepts the descriptor
- core_gnt  in  1  matrix core has finished writing its results
- a_size  out  17-LANE_LOG2  rounded A size
- b_size  out  17-LANE_LOG2  rounded B size
- n_size  out  16  N size, passed through unchanged
- busy  out  1  high from descriptor fetch through write-back
- done_count  out  COUNT_W  number of completed commands, including error completions

## Operation
- Slot k layout:
  - Flag word at SLOT_BASE+4k; bit0 = go.
  - Descriptor word at SLOT_BASE+4k+2: [15:0] a_raw, [31:16] b_raw, [47:32] n.
- Slots are serviced strictly in order. Pointer ptr starts at 0 and advances by one, modulo NUM_SLOTS, after each write-back. The sequencer never skips to a later slot.
- Rounding:
  - a_size = a_raw[15:LANE_LOG2] + (|a_raw[LANE_LOG2-1:0]).
  - b_size is formed the same way from b_raw.
  - Result is zero-extended; there is no overflow (a_raw=0xFFFF, L=3 gives 8192).
- Error: if a_size, b_size or n is zero, the core is not issued and the slot is written back with its error bit set.
- Status word written to the flag word:
  - bit0 = 0, bit1 = 1 (done), bit2 = error.
  - [31:16] = low 16 bits of (done_count+1).
  - All other bits 0.
- FSM states and transitions:
  - POLL_A: addr = flag(ptr). Next state POLL_C.
  - POLL_C: if ctrl_dout[0] && enable, go to FETCH_A; otherwise go to POLL_A.
  - FETCH_A: addr = desc(ptr). Next state FETCH_C.
  - FETCH_C: latch the rounded sizes into output registers. If any size is zero, go to WB with err=1; otherwise go to ISSUE.
  - ISSUE: core_valid=1. When core_ready=1, go to EXEC.
  - EXEC: when core_gnt=1, go to WB.
  - WB: addr = flag(ptr), ctrl_we=1, ctrl_din = status. Increment done_count (wraps at 2^COUNT_W), advance ptr, then go to POLL_A.
- Outside POLL_A/POLL_C, ctrl_addr holds the value for the current state. ctrl_we is high only in WB.
- Size outputs hold their latched value until the next FETCH_C.
- core_gnt is sampled only in EXEC and ignored in every other state. The core guarantees gnt never arrives in the ready cycle.
- enable is sampled only in POLL_C. Dropping enable later has no effect on the in-flight command.
- Reset at any point, including mid-EXEC:
  - State returns to POLL_A; ptr=0, done_count=0.
  - core_valid=0, ctrl_we=0, busy=0, sizes=0, ctrl_din=0.
  - The partly processed slot's flag is left untouched and is re-executed after reset.

## Timing
- BRAM read latency is exactly one cycle; the address is registered into the BRAM in cycle t and dout is used in cycle t+1.
- Poll loop period is 2 cycles per flag read.
- If POLL_C sees go at cycle t, core_valid rises at t+3.
- The handshake completes on the core_ready edge at cycle r. core_valid drops at r+1.
- If core_gnt is sampled at cycle g, the WB write happens at g+1 and the next slot's POLL_A is at g+2.
- Error path: FETCH_C at t+2, WB at t+3. core_valid never asserts.
- With NUM_SLOTS=1, the POLL_A after WB reads the same address. The BRAM returns the written status, so bit0=0 and the command does not re-fire.
- busy is high in FETCH_A..WB inclusive.

## Test plan
- Single command, slot 0:
  - Stimulus: desc a_raw=17, b_raw=16, n=5; core_ready immediately, core_gnt 10 cycles later.
  - Required: a_size=3, b_size=2, n_size=5. core_valid rises 3 cycles after go is seen. Flag word becomes 0x0001_0002. done_count=1.
- Four slots, all go=1, NUM_SLOTS=4:
  - Required: issued in order 0,1,2,3 and then wraps to slot 0. Status sequence fields are 1..4.
- Zero size:
  - Stimulus: slot with b_raw=0.
  - Required: no core_valid. Flag word written as 0x0001_0006. done_count increments.
- Backpressure:
  - Stimulus: core_ready held low 20 cycles; core_gnt pulsed during ISSUE.
  - Required: core_valid and sizes stay stable; the early gnt is ignored; completion follows only the later gnt in EXEC.
- enable low with go=1:
  - Required: polling continues and nothing is issued. Raising enable leads to issue 3 cycles after the next POLL_C.
- rst asserted mid-EXEC:
  - Required: on the next cycle all outputs are at reset values and ptr=0. The command is re-issued after reset because its flag still has go=1.
